unit_arbiter: RTL and testbench

- Shares one ALU and one memory port among N_THREADS thread controllers, enabling a multithreaded core.
- Each thread uses the existing unit handshake toward the arbiter: unit_sel, unit_in, unit_out, unit_ready.
- ALU and MEM are arbitrated independently, so one thread can use the ALU while another uses memory in the same cycle.
- Sits between the thread array and the alu/mem_ctrl blocks.

---
 rtl/unit_arbiter.sv | 173 +++++++++++++++++
 tb/tb_unit_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_arbiter.sv
// unit_arbiter: shares one combinational ALU and one memory port among N_THREADS threads.
// Build option: define UNIT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module unit_arbiter #(
  parameter int N_THREADS = 4,
  parameter int W         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*N_THREADS-1:0]   thr_sel,
  input  logic [3*W*N_THREADS-1:0] thr_in,
  output logic [W*N_THREADS-1:0]   thr_out,
  output logic [N_THREADS-1:0]     thr_ready,
  output logic [3*W-1:0]           alu_in,
  input  logic [W-1:0]             alu_out,
  output logic                     mem_valid,
  output logic [3*W-1:0]           mem_in,
  input  logic [W-1:0]             mem_out,
  input  logic                     mem_ready
);

  localparam int              PW      = $clog2(N_THREADS);
  localparam logic [1:0]      SEL_ALU = 2'd1;
  localparam logic [1:0]      SEL_MEM = 2'd2;
  localparam logic [PW-1:0]   LAST    = PW'(N_THREADS - 1);

  typedef enum logic {MEM_IDLE = 1'b0, MEM_BUSY = 1'b1} mem_state_e;

  mem_state_e           state_q, state_d;
  logic [PW-1:0]        mem_owner_q, mem_owner_d;
  logic [N_THREADS-1:0] alu_req, mem_req;
  logic [PW-1:0]        alu_start, mem_start, alu_win, mem_win;
  logic                 alu_found, mem_found;

  // Returns {found, index}; walking from the farthest slot back lets the nearest requester win.
  function automatic logic [PW:0] rr_pick(input logic [N_THREADS-1:0] req,
                                          input logic [PW-1:0]        start);
    logic [PW:0]   res;
    logic [PW-1:0] idx;
    int            pos;
    res = '0;
    for (int k = N_THREADS - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= N_THREADS) begin
        pos = pos - N_THREADS;
      end else begin
        pos = pos;
      end
      idx = PW'(pos);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == LAST) ? '0 : i + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      alu_req[i] = (thr_sel[2*i +: 2] == SEL_ALU);
      mem_req[i] = (thr_sel[2*i +: 2] == SEL_MEM);
    end
  end

  always_comb begin
    {alu_found, alu_win} = rr_pick(alu_req, alu_start);
    {mem_found, mem_win} = rr_pick(mem_req, mem_start);
  end

`ifdef UNIT_ARB_FIXED_PRIO_EN
  assign alu_start = '0;
  assign mem_start = '0;
`else
  logic [PW-1:0] alu_ptr_q, alu_ptr_d, mem_ptr_q, mem_ptr_d;

  always_comb begin
    alu_ptr_d = alu_ptr_q;
    mem_ptr_d = mem_ptr_q;
    if (alu_found) begin
      alu_ptr_d = next_idx(alu_win);
    end else begin
      alu_ptr_d = alu_ptr_q;
    end
    if ((state_q == MEM_IDLE) && mem_found) begin
      mem_ptr_d = next_idx(mem_win);
    end else begin
      mem_ptr_d = mem_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ptr_q <= '0;
      mem_ptr_q <= '0;
    end else begin
      alu_ptr_q <= alu_ptr_d;
      mem_ptr_q <= mem_ptr_d;
    end
  end

  assign alu_start = alu_ptr_q;
  assign mem_start = mem_ptr_q;
`endif

  // Unit routing is combinational so ALU grants and NONE steps complete in the request cycle.
  always_comb begin
    state_d     = state_q;
    mem_owner_d = mem_owner_q;
    thr_ready   = '0;
    thr_out     = '0;
    alu_in      = '0;
    mem_valid   = 1'b0;
    mem_in      = '0;
    if (rst) begin
      state_d = MEM_IDLE;
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        thr_ready[i] = !alu_req[i] && !mem_req[i];
      end
      if (alu_found) begin
        alu_in                             = thr_in[int'(alu_win)*3*W +: 3*W];
        thr_ready[alu_win]                 = 1'b1;
        thr_out[int'(alu_win)*W +: W]      = alu_out;
      end else begin
        alu_in = '0;
      end
      case (state_q)
        MEM_IDLE: begin
          if (mem_found) begin
            state_d     = MEM_BUSY;
            mem_owner_d = mem_win;
          end else begin
            state_d = MEM_IDLE;
          end
        end
        MEM_BUSY: begin
          // A withdrawn owner still finishes the bus transaction; only the result is dropped.
          mem_valid = 1'b1;
          mem_in    = thr_in[int'(mem_owner_q)*3*W +: 3*W];
          if (mem_ready) begin
            state_d = MEM_IDLE;
            if (mem_req[mem_owner_q]) begin
              thr_ready[mem_owner_q]            = 1'b1;
              thr_out[int'(mem_owner_q)*W +: W] = mem_out;
            end else begin
              state_d = MEM_IDLE;
            end
          end else begin
            state_d = MEM_BUSY;
          end
        end
        default: begin
          state_d = MEM_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      mem_owner_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_owner_q <= mem_owner_d;
    end
  end

endmodule

// File: tb/tb_unit_arbiter.sv
// Self-checking bench for unit_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model of the arbitration rules.
module tb_unit_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [2*N-1:0]   thr_sel;
  logic [3*W*N-1:0] thr_in;
  logic [W*N-1:0]   thr_out;
  logic [N-1:0]     thr_ready;
  logic [3*W-1:0]   alu_in;
  logic [W-1:0]     alu_out;
  logic             mem_valid;
  logic [3*W-1:0]   mem_in;
  logic [W-1:0]     mem_out;
  logic             mem_ready;

  logic [1:0]   sel_a  [N];
  logic [W-1:0] ctrl_a [N];
  logic [W-1:0] op1_a  [N];
  logic [W-1:0] op2_a  [N];

  // reference model state
  int m_busy, m_owner, m_aptr, m_mptr;
  logic [N-1:0]   exp_ready;
  logic [W*N-1:0] exp_out;
  logic [3*W-1:0] exp_alu_in, exp_mem_in;
  logic           exp_mem_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (c[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_in[3*W-1:2*W], alu_in[2*W-1:W], alu_in[W-1:0]);

  unit_arbiter #(.N_THREADS(N), .W(W)) dut (
    .clk(clk), .rst(rst), .thr_sel(thr_sel), .thr_in(thr_in), .thr_out(thr_out),
    .thr_ready(thr_ready), .alu_in(alu_in), .alu_out(alu_out), .mem_valid(mem_valid),
    .mem_in(mem_in), .mem_out(mem_out), .mem_ready(mem_ready)
  );

  function automatic logic [3*W-1:0] slot(input int t);
    return {ctrl_a[t], op1_a[t], op2_a[t]};
  endfunction

  function automatic int first_req(input logic [1:0] kind, input int ptr);
    int start;
`ifdef UNIT_ARB_FIXED_PRIO_EN
    start = 0 * ptr;
`else
    start = ptr;
`endif
    for (int d = 0; d < N; d++) begin
      if (sel_a[(start + d) % N] == kind) return (start + d) % N;
    end
    return -1;
  endfunction

  task automatic model_expect();
    int aw;
    exp_ready = '0; exp_out = '0; exp_alu_in = '0; exp_mem_valid = 1'b0; exp_mem_in = '0;
    if (!rst) begin
      for (int t = 0; t < N; t++) exp_ready[t] = (sel_a[t] != 2'd1) && (sel_a[t] != 2'd2);
      aw = first_req(2'd1, m_aptr);
      if (aw >= 0) begin
        exp_ready[aw] = 1'b1;
        exp_alu_in = slot(aw);
        exp_out[aw*W +: W] = alu_fn(ctrl_a[aw], op1_a[aw], op2_a[aw]);
      end
      if (m_busy != 0) begin
        exp_mem_valid = 1'b1;
        exp_mem_in = slot(m_owner);
        if (mem_ready && sel_a[m_owner] == 2'd2) begin
          exp_ready[m_owner] = 1'b1;
          exp_out[m_owner*W +: W] = mem_out;
        end
      end
    end
  endtask

  task automatic model_advance();
    int aw, mw;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_aptr = 0; m_mptr = 0;
    end else begin
      aw = first_req(2'd1, m_aptr);
      if (aw >= 0) m_aptr = (aw + 1) % N;
      if (m_busy != 0) begin
        if (mem_ready) m_busy = 0;
      end else begin
        mw = first_req(2'd2, m_mptr);
        if (mw >= 0) begin
          m_busy = 1; m_owner = mw; m_mptr = (mw + 1) % N;
        end
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      thr_sel[2*i +: 2]     = sel_a[i];
      thr_in[3*W*i +: 3*W]  = slot(i);
    end
  endtask

  task automatic drive_settle();
    apply();
    #4;
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      sel_a[i] = 2'd0; ctrl_a[i] = '0; op1_a[i] = '0; op2_a[i] = '0;
    end
    mem_ready = 1'b0;
    mem_out   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      sel_a[i] = 2'($urandom_range(0, 3)); op1_a[i] = $urandom; op2_a[i] = $urandom;
    end
    mem_ready = 1'b1; mem_out = 32'hCAFE_F00D;
    drive_settle();
    checks++;
    if ({thr_ready, mem_valid} !== {{N{1'b0}}, 1'b0}) begin
      errors++; $display("FAIL reset_ctrl: got ready=%b valid=%b expected 0/0", thr_ready, mem_valid);
    end
    checks++;
    if ({thr_out, alu_in, mem_in} !== '0) begin
      errors++; $display("FAIL reset_data: got out=%h alu_in=%h mem_in=%h expected 0", thr_out, alu_in, mem_in);
    end
    tick();
    rst = 1'b0;
    clear_all();
    for (int c = 0; c < 3; c++) begin
      drive_settle();
      checks++;
      if ({thr_ready, mem_valid, alu_in} !== {4'b1111, 1'b0, 96'd0}) begin
        errors++; $display("FAIL idle_none c%0d: got ready=%b valid=%b alu_in=%h expected 1111/0/0",
                           c, thr_ready, mem_valid, alu_in);
      end
      tick();
    end
  endtask

  task automatic test_alu_rr();
    clear_all();
    for (int i = 0; i < N; i++) begin
      sel_a[i] = 2'd1; op1_a[i] = 32'(i); op2_a[i] = 32'd10;
    end
    for (int k = 0; k < N; k++) begin
      drive_settle();
      checks++;
      if (thr_ready !== 4'((1 << (k + 1)) - 1) || thr_out[k*W +: W] !== 32'(10 + k)) begin
        errors++; $display("FAIL alu_rr k%0d: got ready=%b out=%h expected ready=%b out=%h",
                           k, thr_ready, thr_out[k*W +: W], 4'((1 << (k + 1)) - 1), 32'(10 + k));
      end
      tick();
      sel_a[k] = 2'd0;
    end
    sel_a[0] = 2'd1; sel_a[2] = 2'd1;
    drive_settle();
    checks++;
    if (thr_ready !== 4'b1011 || thr_out[W-1:0] !== 32'd10) begin
      errors++; $display("FAIL alu_ptr_wrap: got ready=%b out0=%h expected 1011/0000000a", thr_ready, thr_out[W-1:0]);
    end
    tick();
    clear_all();
  endtask

  task automatic test_mem_latency();
    clear_all();
    sel_a[1] = 2'd2; op1_a[1] = 32'h100;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 4);
      mem_out   = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
      drive_settle();
      checks++;
      if (mem_valid !== (c != 0) || thr_ready[1] !== (c == 4)) begin
        errors++; $display("FAIL mem_lat c%0d: got valid=%b ready1=%b expected %b/%b",
                           c, mem_valid, thr_ready[1], (c != 0), (c == 4));
      end
      if (c == 1) begin
        checks++;
        if (mem_in !== {32'h0, 32'h100, 32'h0}) begin
          errors++; $display("FAIL mem_in: got %h expected %h", mem_in, {32'h0, 32'h100, 32'h0});
        end
      end
      if (c == 4) begin
        checks++;
        if (thr_out[W +: W] !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL mem_data: got %h expected deadbeef", thr_out[W +: W]);
        end
      end
      tick();
    end
    clear_all();
  endtask

  task automatic test_alu_mem_overlap();
    clear_all();
    sel_a[0] = 2'd2; op1_a[0] = 32'h200;
    sel_a[2] = 2'd1; op1_a[2] = 32'd3; op2_a[2] = 32'd4;
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c == 2);
      mem_out   = 32'h55;
      drive_settle();
      checks++;
      if (thr_ready[2] !== 1'b1 || thr_out[2*W +: W] !== 32'd7 || thr_ready[0] !== (c == 2)) begin
        errors++; $display("FAIL overlap c%0d: got ready=%b out2=%h expected ready2=1 ready0=%b out2=7",
                           c, thr_ready, thr_out[2*W +: W], (c == 2));
      end
      tick();
    end
    clear_all();
  endtask

  task automatic test_back_to_back();
    int served;
    rst = 1'b1;
    clear_all();
    drive_settle();
    tick();
    rst = 1'b0;
    sel_a[0] = 2'd2; sel_a[3] = 2'd2;
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      mem_out = 32'h1234_0000 + 32'(c);
`ifdef UNIT_ARB_FIXED_PRIO_EN
      served = 0;
`else
      served = (c == 3) ? 3 : 0;
`endif
      drive_settle();
      checks++;
      if (c % 2 == 0) begin
        if (thr_ready !== 4'b0110 || mem_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_idle c%0d: got ready=%b valid=%b expected 0110/0", c, thr_ready, mem_valid);
        end
      end else begin
        if (thr_ready !== (4'b0110 | 4'(1 << served)) || thr_out[served*W +: W] !== 32'h1234_0000 + 32'(c)) begin
          errors++; $display("FAIL b2b_serve c%0d: got ready=%b out=%h expected thread %0d",
                             c, thr_ready, thr_out, served);
        end
      end
      tick();
    end
    clear_all();
  endtask

  task automatic test_reset_busy();
    clear_all();
    sel_a[2] = 2'd2; op1_a[2] = 32'h300;
    drive_settle(); tick();
    drive_settle();
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++; $display("FAIL rb_busy: got valid=%b expected 1", mem_valid);
    end
    tick();
    rst = 1'b1;
    drive_settle();
    checks++;
    if (thr_ready !== 4'b0000 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL rb_in_reset: got ready=%b valid=%b expected 0000/0", thr_ready, mem_valid);
    end
    tick();
    rst = 1'b0;
    sel_a[3] = 2'd2; op1_a[3] = 32'h400;
    drive_settle();
    checks++;
    if (mem_valid !== 1'b0 || thr_ready[3:2] !== 2'b00) begin
      errors++; $display("FAIL rb_after: got valid=%b ready=%b expected 0 and threads 2,3 waiting", mem_valid, thr_ready);
    end
    tick();
    mem_ready = 1'b1; mem_out = 32'h0BAD_F00D;
    drive_settle();
    checks++;
    if (mem_valid !== 1'b1 || mem_in !== {32'h0, 32'h300, 32'h0} || thr_ready[3:2] !== 2'b01
        || thr_out[2*W +: W] !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL rb_fresh: got valid=%b mem_in=%h ready=%b expected owner thread 2",
                         mem_valid, mem_in, thr_ready);
    end
    tick();
    clear_all();
    drive_settle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) sel_a[i] = 2'($urandom_range(0, 3));
        ctrl_a[i] = 32'($urandom_range(0, 3));
        op1_a[i]  = $urandom;
        op2_a[i]  = $urandom;
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_out   = $urandom;
      drive_settle();
      model_expect();
      checks++;
      if (thr_ready !== exp_ready || mem_valid !== exp_mem_valid) begin
        errors++; $display("FAIL rnd_ctrl c%0d: got ready=%b valid=%b expected %b/%b",
                           c, thr_ready, mem_valid, exp_ready, exp_mem_valid);
      end
      checks++;
      if (thr_out !== exp_out) begin
        errors++; $display("FAIL rnd_out c%0d: got %h expected %h", c, thr_out, exp_out);
      end
      checks++;
      if (alu_in !== exp_alu_in || mem_in !== exp_mem_in) begin
        errors++; $display("FAIL rnd_bus c%0d: got alu=%h mem=%h expected alu=%h mem=%h",
                           c, alu_in, mem_in, exp_alu_in, exp_mem_in);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    apply();
    m_busy = 0; m_owner = 0; m_aptr = 0; m_mptr = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_alu_rr();
    test_mem_latency();
    test_alu_mem_overlap();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
